// File: rtl/md5_crack_pkg.sv
// Shared definitions for the MD5 brute-force search controller.
//   MSG_W   : width of candidate messages and digests
//   STAGES  : number of pipeline stages behind the issue register
//   MD5_*   : MD5 initial chaining values, concatenated as MD5_IV
//   state_e : controller FSM states
package md5_crack_pkg;

  localparam int MSG_W  = 128;
  localparam int STAGES = 1;

  localparam logic [31:0] MD5_A = 32'h67452301;
  localparam logic [31:0] MD5_B = 32'hefcdab89;
  localparam logic [31:0] MD5_C = 32'h98badcfe;
  localparam logic [31:0] MD5_D = 32'h10325476;
  localparam logic [MSG_W-1:0] MD5_IV = {MD5_A, MD5_B, MD5_C, MD5_D};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/md5_crack_cmp.sv
// Stage-2 of the search pipeline: captures the candidate and the digest the
// core produced for it, then compares that digest against the target.
//   clk, rst  : clock, async active-low reset
//   cap       : stage 1 holds a fresh candidate this cycle
//   s2_vld    : stage-2 valid bit (owned by the controller's valid pipe)
//   s1_msg    : candidate currently on the core input
//   s1_digest : digest the core returns for s1_msg
//   target    : latched digest to search for
//   s2_msg    : candidate held in stage 2
//   hit       : stage 2 is valid and its digest equals target
module md5_crack_cmp
  import md5_crack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic             s2_vld,
  input  logic [MSG_W-1:0] s1_msg,
  input  logic [MSG_W-1:0] s1_digest,
  input  logic [MSG_W-1:0] target,
  output logic [MSG_W-1:0] s2_msg,
  output logic             hit
);

  logic [MSG_W-1:0] s2_digest;

  // Only load on a fresh candidate so the wide registers sit still while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_msg    <= '0;
      s2_digest <= '0;
    end else if (cap) begin
      s2_msg    <= s1_msg;
      s2_digest <= s1_digest;
    end
  end

  assign hit = s2_vld && (s2_digest == target);

endmodule

// File: rtl/md5_crack_ctrl.sv
// Search controller for an external combinational MD5 core. Issues candidates
// base, base+1, ... (mod 2^128) one per cycle, compares each returned digest
// against target one cycle later, and stops on the first match or after count
// candidates.
//   clk, rst      : clock, async active-low reset
//   start         : launch pulse, honoured in IDLE/DONE only
//   abort         : return to IDLE from anywhere, clears results
//   target/base/count : search parameters, latched on accepted start
//   core_message  : registered candidate to the core
//   core_new      : core_message holds a fresh candidate
//   core_digest   : core's digest of core_message
//   busy/done     : RUN or DRAIN / DONE
//   found, found_value : first matching candidate
//   attempts      : candidates compared so far (saturating)
module md5_crack_ctrl
  import md5_crack_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [MSG_W-1:0] target,
  input  logic [MSG_W-1:0] base,
  input  logic [CNT_W-1:0] count,
  output logic [MSG_W-1:0] core_message,
  output logic             core_new,
  input  logic [MSG_W-1:0] core_digest,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [MSG_W-1:0] found_value,
  output logic [CNT_W-1:0] attempts
);

  state_e           state_q, state_d;
  logic [MSG_W-1:0] target_q, base_q;
  logic [CNT_W-1:0] count_q, issue_cnt;
  // [0] = stage 1 (core_message), [STAGES] = stage 2 (compare register)
  logic [STAGES:0]  vld_pipe;
  logic [MSG_W-1:0] s2_msg;
  logic             hit;
  logic             launch, issue, flush;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    if (abort) begin
      // abort beats both a coincident start and a coincident match
      state_d = IDLE;
      flush   = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            launch  = 1'b1;
            state_d = (count != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (hit) begin
            state_d = DONE;
            flush   = 1'b1;
          end else if (issue_cnt == count_q) begin
            state_d = DRAIN;
          end else begin
            issue = 1'b1;
          end
        end
        DRAIN: begin
          if (hit) begin
            state_d = DONE;
            flush   = 1'b1;
          end else if (vld_pipe == '0) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // ------------------------------------------------ search parameters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q  <= '0;
      base_q    <= '0;
      count_q   <= '0;
      issue_cnt <= '0;
    end else if (launch) begin
      target_q  <= target;
      base_q    <= base;
      count_q   <= count;
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

  // ------------------------------------------ stage 1 and valid pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_message <= '0;
      vld_pipe     <= '0;
    end else begin
      // flush kills everything behind the match; issue is already low then
      vld_pipe <= {vld_pipe[STAGES-1:0] & {STAGES{~flush}}, issue};
      if (abort)      core_message <= '0;
      else if (issue) core_message <= base_q + MSG_W'(issue_cnt);
    end
  end

  assign core_new = vld_pipe[0];

  // ---------------------------------------------- stage 2 and compare
  md5_crack_cmp u_cmp (
    .clk       (clk),
    .rst       (rst),
    .cap       (vld_pipe[0]),
    .s2_vld    (vld_pipe[STAGES]),
    .s1_msg    (core_message),
    .s1_digest (core_digest),
    .target    (target_q),
    .s2_msg    (s2_msg),
    .hit       (hit)
  );

  // ---------------------------------------------------------- results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      found       <= 1'b0;
      found_value <= '0;
      attempts    <= '0;
    end else if (abort || launch) begin
      found       <= 1'b0;
      found_value <= '0;
      attempts    <= '0;
    end else begin
      // the matching entry itself counts as an attempt
      if (vld_pipe[STAGES] && (attempts != '1)) attempts <= attempts + CNT_W'(1);
      if (hit) begin
        found       <= 1'b1;
        found_value <= s2_msg;
      end
    end
  end

endmodule

// File: tb/tb_md5_crack_ctrl.sv
// Scoreboard bench for md5_crack_ctrl. A stand-in core (message xor MD5 IV)
// closes the loop; candidate and result expectations are queued by the
// stimulus and retired by an independent negedge monitor.
module tb_md5_crack_ctrl;
  import md5_crack_pkg::*;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic             found;
    logic [MSG_W-1:0] fv;
    logic [CNT_W-1:0] att;
  } res_t;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [MSG_W-1:0] target, base;
  logic [CNT_W-1:0] count;
  logic [MSG_W-1:0] core_message, core_digest, found_value;
  logic             core_new, busy, done, found;
  logic [CNT_W-1:0] attempts;

  logic [MSG_W-1:0] msg_q[$];
  res_t             res_q[$];
  int               total  = 0;
  int               passed = 0;
  logic             done_d = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [MSG_W-1:0] dig(input logic [MSG_W-1:0] m);
    return m ^ MD5_IV;
  endfunction

  assign core_digest = dig(core_message);

  md5_crack_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .base        (base),
    .count       (count),
    .core_message(core_message),
    .core_new    (core_new),
    .core_digest (core_digest),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_value (found_value),
    .attempts    (attempts)
  );

  function automatic void chk(input string name, input logic [MSG_W-1:0] act,
                              input logic [MSG_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endfunction

  // monitor: retire one candidate per core_new cycle, one result per done rise
  always @(negedge clk) begin
    res_t r;
    if (core_new) begin
      if (msg_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_candidate: got %h want none", core_message);
      end else begin
        chk("candidate", core_message, msg_q.pop_front());
      end
    end
    if (done && !done_d) begin
      if (res_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 want no result");
      end else begin
        r = res_q.pop_front();
        chk("found", {127'd0, found}, {127'd0, r.found});
        if (r.found) chk("found_value", found_value, r.fv);
        chk("attempts", MSG_W'(attempts), MSG_W'(r.att));
      end
    end
    done_d = done;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_core_new"},    {127'd0, core_new}, '0);
    chk({tag, "_core_message"}, core_message,      '0);
    chk({tag, "_busy"},        {127'd0, busy},     '0);
    chk({tag, "_done"},        {127'd0, done},     '0);
    chk({tag, "_found"},       {127'd0, found},    '0);
    chk({tag, "_found_value"}, found_value,        '0);
    chk({tag, "_attempts"},    MSG_W'(attempts),   '0);
  endtask

  task automatic launch(input logic [MSG_W-1:0] t, input logic [MSG_W-1:0] b,
                        input logic [CNT_W-1:0] c);
    @(negedge clk);
    target = t; base = b; count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic abort_pulse();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  // Bounded wait for done; reports when watch appeared, core_new cycles and
  // busy cycles without a fresh candidate.
  task automatic wait_done(input logic [MSG_W-1:0] watch, output int lat,
                           output int newc, output int drainc);
    int  cyc  = 0;
    int  seen = -100;
    bit  ok   = 1'b0;
    newc = 0; drainc = 0;
    for (int i = 0; i < 64; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (core_new) newc++;
      if (core_new && core_message == watch) seen = i;
      if (i > 0 && busy && !core_new) drainc++;
      @(negedge clk);
      cyc = i + 1;
    end
    lat = cyc - seen;
    if (!ok) begin
      total++;
      $display("FAIL done_timeout: got done=0 want done=1 within 64 cycles");
    end
  endtask

  initial begin
    logic [MSG_W-1:0] n;
    int lat, newc, drc;
    start = 1'b0; abort = 1'b0; target = '0; base = '0; count = '0; rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // hit: 0x105 is the sixth candidate; one trailing candidate gets flushed
    for (int i = 0; i < 7; i++) msg_q.push_back(MSG_W'(32'h100 + i));
    res_q.push_back('{1'b1, 128'h105, 32'd6});
    launch(dig(128'h105), 128'h100, 16);
    wait_done(128'h105, lat, newc, drc);
    chk("hit_latency", MSG_W'(lat), 128'd2);

    // miss
    for (int i = 0; i < 8; i++) msg_q.push_back(MSG_W'(i));
    res_q.push_back('{1'b0, 128'h0, 32'd8});
    launch(dig(128'hFFFF_FFFF), 128'h0, 8);
    wait_done(128'hDEAD, lat, newc, drc);
    chk("miss_core_new_cycles", MSG_W'(newc), 128'd8);
    chk("miss_drain_seen", {127'd0, drc >= 1}, 128'd1);

    // wrap, relaunched straight from DONE
    n = '1;
    msg_q.push_back(n - 1);
    msg_q.push_back(n);
    msg_q.push_back(128'h0);
    msg_q.push_back(128'h1);
    res_q.push_back('{1'b0, 128'h0, 32'd4});
    launch(dig(128'h5), n - 1, 4);
    chk("relaunch_attempts_clr", MSG_W'(attempts), '0);
    chk("relaunch_busy", {127'd0, busy}, 128'd1);
    wait_done(128'hDEAD, lat, newc, drc);

    abort_pulse();
    chk("abort_from_done", {127'd0, done}, '0);

    // empty search
    res_q.push_back('{1'b0, 128'h0, 32'd0});
    launch(dig(128'h1), 128'h0, 0);
    chk("empty_done", {127'd0, done}, 128'd1);
    chk("empty_busy", {127'd0, busy}, '0);
    repeat (3) @(negedge clk);
    chk("empty_attempts", MSG_W'(attempts), '0);

    // abort coincident with a match, plus an ignored start mid-run
    for (int i = 0; i < 5; i++) msg_q.push_back(MSG_W'(32'h100 + i));
    launch(dig(128'h103), 128'h100, 16);
    @(negedge clk); start = 1'b1; base = 128'h900; count = 1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_done", {127'd0, done}, '0);
    chk("abort_found", {127'd0, found}, '0);
    chk("abort_busy", {127'd0, busy}, '0);
    chk("abort_core_new", {127'd0, core_new}, '0);
    chk("abort_attempts", MSG_W'(attempts), '0);

    // asynchronous reset mid-run
    msg_q.push_back(128'h200);
    msg_q.push_back(128'h201);
    launch(dig(128'hFFFF), 128'h200, 16);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle_busy", {127'd0, busy}, '0);
    chk("post_reset_idle_done", {127'd0, done}, '0);

    msg_q.push_back(128'h5);
    res_q.push_back('{1'b0, 128'h0, 32'd1});
    launch(dig(128'h63), 128'h5, 1);
    wait_done(128'hDEAD, lat, newc, drc);

    repeat (3) @(negedge clk);
    chk("candidates_drained", MSG_W'(msg_q.size()), '0);
    chk("results_drained", MSG_W'(res_q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1);
  end

endmodule
